if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register.
//  - Owns the architectural PC and issues one-outstanding-request fetches to the instruction memory.
//  - Consumes pc_flush, pc_stall, id_stall and flush_addr from the hazard unit.
//  - Delivers {valid, pc, instr} to decode; control hazards are resolved by flush (predict not-taken).
// PARAMETERS
//  W         32             datapath / address width
//  RESET_PC  32'hBFC0_0000  PC value loaded at reset
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  rst          in   1  asynchronous, active-high reset
//  pc_flush     in   1  redirect PC to flush_addr; kill younger fetch state
//  pc_stall     in   1  hold PC; issue no new request
//  id_stall     in   1  hold IF/ID register contents
//  flush_addr   in   W  redirect target, valid when pc_flush=1
//  imem_req     out  1  fetch request valid
//  imem_addr    out  W  fetch address (= PC)
//  imem_gnt     in   1  request accepted this cycle (meaningful only when imem_req=1)
//  imem_rvalid  in   1  response valid; exactly one per granted request, earliest next cycle
//  imem_rdata   in   W  instruction word
//  ifid_valid   out  1  IF/ID holds a real instruction
//  ifid_pc      out  W  PC of the IF/ID instruction
//  ifid_instr   out  W  instruction word (32'h0 = NOP when invalid)
// BEHAVIOUR
//  Reset (async, any cycle, any state):
//    pc=RESET_PC, state=S_REQ, imem_req=0 while rst high;
//    ifid_valid=0, ifid_pc=0, ifid_instr=0; in-flight request and skid buffer discarded.
//  Priority: pc_flush > pc_stall/id_stall.
//  imem_req=1 only in S_REQ with !pc_stall && !pc_flush && !rst; imem_addr=pc. Request is
//    not required to stay asserted until granted.
//  FSM:
//  S_REQ:
//    - req && gnt: infl_pc<=pc, pc<=pc+4 (mod 2^W, wraps), -> S_WAIT.
//    - pc_flush: pc<=flush_addr, stay S_REQ.
//  S_WAIT on rvalid:
//    - !id_stall: ifid<={1, infl_pc, rdata}, -> S_REQ.
//    - id_stall: see CONFIGURATION.
//  S_WAIT on pc_flush without rvalid: pc<=flush_addr, -> S_DRAIN.
//  S_WAIT on pc_flush with rvalid same cycle: response discarded, pc<=flush_addr, -> S_REQ.
//  S_DRAIN: wait for rvalid, discard data, -> S_REQ. A further pc_flush here updates pc only.
//  IF/ID register:
//    - pc_flush: ifid_valid<=0, ifid_instr<=0 (overrides id_stall).
//    - else id_stall: hold.
//    - else: load the new instruction if delivered this cycle, otherwise bubble (ifid_valid<=0).
//  Throughput: one instruction per 2 cycles with single-cycle memory (req/gnt, then rvalid).
//  Latency: gnt at edge N, rvalid at N+1 -> ifid_valid visible after edge N+1.
// CONFIGURATION
//  FETCH_SKID_EN defined:
//    - S_WAIT rvalid with id_stall: word + infl_pc go to 1-entry skid buffer, -> S_HOLD.
//    - S_HOLD, !id_stall: skid -> IF/ID, -> S_REQ.
//    - S_HOLD, pc_flush: clear skid, pc<=flush_addr, -> S_REQ.
//  FETCH_SKID_EN undefined:
//    - No S_HOLD. S_WAIT rvalid with id_stall discards the response, sets pc<=infl_pc
//      (re-fetch), -> S_REQ.
// TESTING
//  1. Reset release, gnt=1, rvalid next cycle, rdata=32'h2408_0001 -> imem_addr=BFC0_0000,
//     then ifid={1, BFC0_0000, 2408_0001}; next imem_addr=BFC0_0004.
//  2. pc_flush=1 with flush_addr=0000_0100 in S_WAIT, rvalid one cycle later
//     -> ifid_valid=0, late rdata dropped, next imem_addr=0000_0100.
//  3. pc_stall=id_stall=1 for 3 cycles in S_REQ -> imem_req=0 and ifid held all 3 cycles;
//     same pc requested after release.
//  4. id_stall=1 while rvalid (rdata=0x8C09_0000 @0x...08):
//     - skid on: delivered from skid when id_stall drops, no refetch.
//     - skid off: address 0x...08 refetched.
//  5. pc_flush + pc_stall same cycle, flush_addr=0000_0200 -> pc=0000_0200, ifid_valid=0.
//  6. RESET_PC=32'hFFFF_FFFC, fetch granted -> next imem_addr=0000_0000 (wrap);
//     rst asserted in S_WAIT -> ifid_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage plus IF/ID pipeline register. Owns the
//   architectural PC and keeps at most one instruction-memory request
//   outstanding. Control hazards are resolved by flushing (predict not-taken).
//
// Parameters
//   W         datapath / address width
//   RESET_PC  PC value loaded at reset
//
// Ports
//   clk, rst      single clock; asynchronous active-high reset
//   pc_flush      redirect PC to flush_addr, kill younger fetch state
//   pc_stall      hold PC, issue no new request
//   id_stall      hold IF/ID register contents
//   flush_addr    redirect target (valid with pc_flush)
//   imem_req/addr fetch request and address (= PC)
//   imem_gnt      request accepted this cycle
//   imem_rvalid   response valid (one per granted request)
//   imem_rdata    instruction word
//   ifid_valid/pc/instr  IF/ID register toward decode (instr = 0 when invalid)
//
// Build option
//   FETCH_SKID_EN  when defined, a response that arrives while decode is
//                  stalled is parked in a 1-entry skid buffer instead of being
//                  dropped and refetched.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int unsigned  W        = 32,
    parameter logic [W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_flush,
    input  logic         pc_stall,
    input  logic         id_stall,
    input  logic [W-1:0] flush_addr,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic         ifid_valid,
    output logic [W-1:0] ifid_pc,
    output logic [W-1:0] ifid_instr
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef FETCH_SKID_EN
    localparam logic [1:0] S_HOLD  = 2'd3;
`endif

    logic [1:0]   state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] infl_pc_q, infl_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [W-1:0] ifid_pc_q, ifid_pc_d;
    logic [W-1:0] ifid_instr_q, ifid_instr_d;
`ifdef FETCH_SKID_EN
    logic [W-1:0] skid_pc_q, skid_pc_d;
    logic [W-1:0] skid_instr_q, skid_instr_d;
`endif

    // An instruction handed to IF/ID this cycle (subject to flush/stall below).
    logic         deliver;
    logic [W-1:0] deliver_pc;
    logic [W-1:0] deliver_instr;

    assign imem_req  = (state_q == S_REQ) && !pc_stall && !pc_flush && !rst;
    assign imem_addr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        infl_pc_d     = infl_pc_q;
        deliver       = 1'b0;
        deliver_pc    = infl_pc_q;
        deliver_instr = imem_rdata;
`ifdef FETCH_SKID_EN
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
`endif
        case (state_q)
            S_REQ: begin
                if (pc_flush) begin
                    pc_d = flush_addr;
                end else if (imem_req && imem_gnt) begin
                    infl_pc_d = pc_q;
                    pc_d      = pc_q + W'(4);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_flush) begin
                    // A response arriving with the flush closes the request; otherwise
                    // it is still owed and must be drained.
                    pc_d    = flush_addr;
                    state_d = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    if (!id_stall) begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end else begin
`ifdef FETCH_SKID_EN
                        skid_pc_d    = infl_pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
`else
                        // Drop the word and rewind so it is fetched again.
                        pc_d    = infl_pc_q;
                        state_d = S_REQ;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (pc_flush) begin
                    pc_d = flush_addr;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_SKID_EN
            S_HOLD: begin
                if (pc_flush) begin
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    pc_d         = flush_addr;
                    state_d      = S_REQ;
                end else if (!id_stall) begin
                    deliver       = 1'b1;
                    deliver_pc    = skid_pc_q;
                    deliver_instr = skid_instr_q;
                    state_d       = S_REQ;
                end
            end
`endif
            default: state_d = S_REQ;
        endcase
    end

    // IF/ID register: flush beats stall; an unstalled cycle without a new
    // instruction inserts a bubble (NOP).
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (pc_flush) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
        end else if (!id_stall) begin
            if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = deliver_pc;
                ifid_instr_d = deliver_instr;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            infl_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
`ifdef FETCH_SKID_EN
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            infl_pc_q    <= infl_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
`ifdef FETCH_SKID_EN
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`endif
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A random-latency memory serves
//   fetches from a fixed address->word function. The reference model is the
//   architectural instruction stream: decode must see PCs in sequence
//   (+4, wrapping), restarting at flush_addr after every flush and at RESET_PC
//   after every reset, with each word equal to the memory word at that PC.
//   A separate wrap instance checks a RESET_PC at the top of the address space.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_flush, pc_stall, id_stall;
    logic [31:0] flush_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr;

    logic        rst_w;
    logic        w_req, w_ifid_valid;
    logic [31:0] w_addr, w_ifid_pc, w_ifid_instr;

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;
    int n_gnt    = 0;
    int gnt_pct  = 100;
    int lat_fix  = 1;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .pc_flush   (pc_flush),
        .pc_stall   (pc_stall),
        .id_stall   (id_stall),
        .flush_addr (flush_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ifid_valid (ifid_valid),
        .ifid_pc    (ifid_pc),
        .ifid_instr (ifid_instr)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .rst        (rst_w),
        .pc_flush   (1'b0),
        .pc_stall   (1'b0),
        .id_stall   (1'b0),
        .flush_addr (32'h0),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_gnt   (1'b1),
        .imem_rvalid(1'b0),
        .imem_rdata (32'h0),
        .ifid_valid (w_ifid_valid),
        .ifid_pc    (w_ifid_pc),
        .ifid_instr (w_ifid_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h2408_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_redirect(input logic [31:0] a);
        exp_q.delete();
        exp_q.push_back(a);
    endtask

    // Applied at a negedge; takes effect at the following posedge.
    task automatic drive(input logic f, input logic [31:0] fa, input logic ps, input logic is);
        pc_flush   = f;
        flush_addr = fa;
        pc_stall   = ps;
        id_stall   = is;
        if (f) model_redirect(fa);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        model_redirect(RESET_PC);
        #2;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory: random grant, one outstanding request, response 1..3 cycles later.
    logic        pend = 1'b0;
    logic [31:0] paddr;
    int          cnt;
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pend        = 1'b0;
            end
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        if (rst) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
        end else if (imem_req && imem_gnt) begin
            if (pend) begin
                n_checks++;
                n_errors++;
                $display("FAIL one_outstanding: request granted at %h while %h pending",
                         imem_addr, paddr);
            end
            pend  = 1'b1;
            paddr = imem_addr;
            cnt   = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
            n_gnt++;
        end
    end

    // Monitor: classify every edge by the controls applied at it.
    logic        prev_valid;
    logic [31:0] prev_pc, prev_instr, e;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("rst_ifid_valid", 32'(ifid_valid), 32'h0);
            check("rst_ifid_pc", ifid_pc, 32'h0);
            check("rst_ifid_instr", ifid_instr, 32'h0);
        end else if (pc_flush) begin
            check("flush_valid", 32'(ifid_valid), 32'h0);
            check("flush_instr", ifid_instr, 32'h0);
        end else if (id_stall) begin
            check("hold_valid", 32'(ifid_valid), 32'(prev_valid));
            check("hold_pc", ifid_pc, prev_pc);
            check("hold_instr", ifid_instr, prev_instr);
        end else if (ifid_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got pc %h expected no instruction", ifid_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", ifid_pc, e);
                check("sb_instr", ifid_instr, mem_word(e));
                exp_q.push_back(e + 32'd4);
                n_deliv++;
            end
        end else begin
            check("bubble_instr", ifid_instr, 32'h0);
        end
        prev_valid = ifid_valid;
        prev_pc    = ifid_pc;
        prev_instr = ifid_instr;
    end

    initial begin
        int  n0;
        bit  found;
        bit  f, ps, is;
        logic [31:0] fa, tmp;

        rst   = 1'b1;
        rst_w = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        model_redirect(RESET_PC);
        repeat (2) @(negedge clk);
        #2;
        check("reset_req", 32'(imem_req), 32'h0);
        check("reset_addr", imem_addr, RESET_PC);
        check("reset_ifid_valid", 32'(ifid_valid), 32'h0);
        check("w_reset_addr", w_addr, 32'hFFFF_FFFC);
        check("w_reset_ifid_pc", w_ifid_pc, 32'h0);

        // First fetch after reset, single-cycle memory.
        @(negedge clk);
        rst   = 1'b0;
        rst_w = 1'b0;
        #2;
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, RESET_PC);
        check("w_first_req", 32'(w_req), 32'h1);
        @(negedge clk);
        #2;
        check("pc_incr", imem_addr, RESET_PC + 32'd4);
        check("w_wrap_addr", w_addr, 32'h0000_0000);
        rst_w = 1'b1;
        #1;
        check("w_rst_ifid_valid", 32'(w_ifid_valid), 32'h0);
        check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
        check("w_rst_instr", w_ifid_instr, 32'h0);

        // pc_stall + id_stall for three cycles in S_REQ.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            #2;
            check("stall_req", 32'(imem_req), 32'h0);
            check("stall_ifid_valid", 32'(ifid_valid), 32'h1);
            check("stall_ifid_pc", ifid_pc, RESET_PC);
            check("stall_ifid_instr", ifid_instr, mem_word(RESET_PC));
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        check("unstall_req", 32'(imem_req), 32'h1);
        check("unstall_addr", imem_addr, RESET_PC + 32'd4);
        n0 = n_gnt;

        // Response arrives while decode is stalled.
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifid_valid && ifid_pc == RESET_PC + 32'd4) begin
                found = 1'b1;
                break;
            end
        end
        check("stalled_word_delivered", 32'(found), 32'h1);
`ifdef FETCH_SKID_EN
        check("skid_no_refetch", 32'(n_gnt - n0), 32'd0);
`else
        check("refetch_count", 32'(n_gnt - n0), 32'd1);
`endif

        // Flush and stall together in S_REQ.
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b0);
        lat_fix = 2;
        #2;
        check("flushstall_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        check("flushstall_addr", imem_addr, 32'h0000_0200);
        check("flushstall_req2", 32'(imem_req), 32'h1);
        check("flushstall_valid", 32'(ifid_valid), 32'h0);

        // Flush in S_WAIT, response one cycle later must be dropped.
        @(negedge clk);
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        check("drain_valid", 32'(ifid_valid), 32'h0);
        @(negedge clk);
        #2;
        check("drain_done_valid", 32'(ifid_valid), 32'h0);
        check("drain_done_addr", imem_addr, 32'h0000_0100);
        check("drain_done_req", 32'(imem_req), 32'h1);
        gnt_pct = 70;
        lat_fix = 0;

        // Random phase.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(999) < 4) begin
                do_reset();
                continue;
            end
            f   = ($urandom_range(99) < 6);
            ps  = ($urandom_range(99) < 20);
            is  = ($urandom_range(99) < 25);
            tmp = $urandom();
            fa  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'hC))
                                           : {tmp[31:2], 2'b00};
            drive(f, fa, ps, is);
            #2;
            if (f || ps) check("req_blocked", 32'(imem_req), 32'h0);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("progress", 32'(n_deliv >= 200), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
